// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// Hazard-detection and forwarding controller for the 5-stage MIPS pipeline.
// Mirrors the EX/MEM/WB instructions to drive stalls, branch flushes, EX forwarding and ID bypass.
module pipe_hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int BR_FLUSH = 3,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [REG_AW-1:0] id_wr_reg,
   input  logic              br_taken,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              flush_exmem,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              id_byp_a,
   output logic              id_byp_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              v;
      logic              we;
      logic              ld;
      logic [REG_AW-1:0] wr;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              urs;
      logic              urt;
   } sb_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   sb_t  id_entry;
   sb_t  ex_q;
   sb_t  mem_q;
   sb_t  wb_q;
   logic ex_ld_hit;
   logic mem_ld_hit;
   logic load_use;
   logic branch;
   logic stall;
   logic wb_src_unused;

   // A stage produces a source only for a real, writing instruction; register 0 never matches.
   function automatic logic src_hit(input sb_t s, input logic [REG_AW-1:0] src, input logic use_src);
      return s.v && s.we && (s.wr == src) && (src != '0) && use_src;
   endfunction

   function automatic logic [1:0] fwd_sel(input sb_t mem_e, input sb_t wb_e,
                                          input logic [REG_AW-1:0] src, input logic use_src);
      if (src_hit(mem_e, src, use_src) && !mem_e.ld)
         return 2'b10;
      if (src_hit(wb_e, src, use_src) && (!wb_e.ld || (LOAD_LAT == 1)))
         return 2'b01;
      return 2'b00;
   endfunction

   assign id_entry = {id_valid, id_reg_write, id_mem_read, id_wr_reg,
                      id_rs, id_rt, id_use_rs, id_use_rt};

   assign ex_ld_hit  = ex_q.ld  && (src_hit(ex_q,  id_rs, id_use_rs) || src_hit(ex_q,  id_rt, id_use_rt));
   assign mem_ld_hit = mem_q.ld && (src_hit(mem_q, id_rs, id_use_rs) || src_hit(mem_q, id_rt, id_use_rt));
   assign load_use   = id_valid && (ex_ld_hit || ((LOAD_LAT == 2) && mem_ld_hit));

   // A taken branch kills the consumer anyway, so it overrides the load-use stall.
   assign branch = br_taken && !rst;
   assign stall  = load_use && !branch && !rst;

   assign pc_en       = !stall;
   assign ifid_en     = !stall;
   assign flush_ifid  = branch && (BR_FLUSH >= 1);
   assign flush_idex  = stall || (branch && (BR_FLUSH >= 2));
   assign flush_exmem = branch && (BR_FLUSH == 3);

   assign fwd_a = (rst || !ex_q.v) ? 2'b00 : fwd_sel(mem_q, wb_q, ex_q.rs, ex_q.urs);
   assign fwd_b = (rst || !ex_q.v) ? 2'b00 : fwd_sel(mem_q, wb_q, ex_q.rt, ex_q.urt);

   assign id_byp_a = !rst && src_hit(wb_q, id_rs, id_use_rs);
   assign id_byp_b = !rst && src_hit(wb_q, id_rt, id_use_rt);

   // WB keeps its source fields only so the scoreboard mirrors every stage in full.
   assign wb_src_unused = ^{wb_q.rs, wb_q.rt, wb_q.urs, wb_q.urt};

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= flush_exmem ? '0 : ex_q;
         ex_q  <= flush_idex  ? '0 : id_entry;
         if (stall && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_ONE;
         if (br_taken && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// Directed scoreboard bench for pipe_hazard_ctrl: one LOAD_LAT=1/CNT_W=4 instance
// and one LOAD_LAT=2/CNT_W=16 instance, each with its own instruction stream.
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic       v;
      logic       urs;
      logic       urt;
      logic       we;
      logic       ld;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wr;
   } ins_t;

   typedef struct packed {
      logic       pc_en;
      logic       ifid_en;
      logic       flush_ifid;
      logic       flush_idex;
      logic       flush_exmem;
      logic [1:0] fwd_a;
      logic [1:0] fwd_b;
      logic       id_byp_a;
      logic       id_byp_b;
   } ctl_t;

   typedef struct {
      int          dut;
      int          kind;
      logic [31:0] value;
      string       tag;
   } exp_t;

   localparam ins_t NOP   = '0;
   localparam int   K_CTL = 0;
   localparam int   K_STL = 1;
   localparam int   K_FLS = 2;

   logic clk = 1'b0;
   logic rst;
   ins_t in1, in2;
   logic br1, br2;

   logic       pc_en1, ifid_en1, fl_ifid1, fl_idex1, fl_exmem1, byp_a1, byp_b1;
   logic [1:0] fwd_a1, fwd_b1;
   logic [3:0] scnt1, fcnt1;
   logic       pc_en2, ifid_en2, fl_ifid2, fl_idex2, fl_exmem2, byp_a2, byp_b2;
   logic [1:0] fwd_a2, fwd_b2;
   logic [15:0] scnt2, fcnt2;
   ctl_t       ctl1, ctl2;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_FLUSH(3), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst),
      .id_valid(in1.v), .id_rs(in1.rs), .id_rt(in1.rt),
      .id_use_rs(in1.urs), .id_use_rt(in1.urt),
      .id_reg_write(in1.we), .id_mem_read(in1.ld), .id_wr_reg(in1.wr),
      .br_taken(br1),
      .pc_en(pc_en1), .ifid_en(ifid_en1),
      .flush_ifid(fl_ifid1), .flush_idex(fl_idex1), .flush_exmem(fl_exmem1),
      .fwd_a(fwd_a1), .fwd_b(fwd_b1), .id_byp_a(byp_a1), .id_byp_b(byp_b1),
      .stall_cnt(scnt1), .flush_cnt(fcnt1)
   );

   pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(2), .BR_FLUSH(3), .CNT_W(16)) u_dut2 (
      .clk(clk), .rst(rst),
      .id_valid(in2.v), .id_rs(in2.rs), .id_rt(in2.rt),
      .id_use_rs(in2.urs), .id_use_rt(in2.urt),
      .id_reg_write(in2.we), .id_mem_read(in2.ld), .id_wr_reg(in2.wr),
      .br_taken(br2),
      .pc_en(pc_en2), .ifid_en(ifid_en2),
      .flush_ifid(fl_ifid2), .flush_idex(fl_idex2), .flush_exmem(fl_exmem2),
      .fwd_a(fwd_a2), .fwd_b(fwd_b2), .id_byp_a(byp_a2), .id_byp_b(byp_b2),
      .stall_cnt(scnt2), .flush_cnt(fcnt2)
   );

   assign ctl1 = {pc_en1, ifid_en1, fl_ifid1, fl_idex1, fl_exmem1, fwd_a1, fwd_b1, byp_a1, byp_b1};
   assign ctl2 = {pc_en2, ifid_en2, fl_ifid2, fl_idex2, fl_exmem2, fwd_a2, fwd_b2, byp_a2, byp_b2};

   always #5 clk = ~clk;

   function automatic ins_t alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
      ins_t i;
      i = '0;
      i.v = 1'b1; i.urs = 1'b1; i.urt = 1'b1; i.we = 1'b1;
      i.rs = a; i.rt = b; i.wr = d;
      return i;
   endfunction

   function automatic ins_t lw(input logic [4:0] d, input logic [4:0] a);
      ins_t i;
      i = '0;
      i.v = 1'b1; i.urs = 1'b1; i.we = 1'b1; i.ld = 1'b1;
      i.rs = a; i.wr = d;
      return i;
   endfunction

   function automatic ins_t rd(input logic [4:0] a, input logic [4:0] b);
      ins_t i;
      i = '0;
      i.v = 1'b1; i.urs = 1'b1; i.urt = 1'b1;
      i.rs = a; i.rt = b;
      return i;
   endfunction

   function automatic ctl_t ok(input logic [1:0] fa, input logic [1:0] fb, input logic ba, input logic bb);
      ctl_t c;
      c = '0;
      c.pc_en = 1'b1; c.ifid_en = 1'b1;
      c.fwd_a = fa; c.fwd_b = fb; c.id_byp_a = ba; c.id_byp_b = bb;
      return c;
   endfunction

   function automatic ctl_t stl(input logic [1:0] fa, input logic [1:0] fb);
      ctl_t c;
      c = '0;
      c.flush_idex = 1'b1;
      c.fwd_a = fa; c.fwd_b = fb;
      return c;
   endfunction

   function automatic ctl_t brf();
      ctl_t c;
      c = '0;
      c.pc_en = 1'b1; c.ifid_en = 1'b1;
      c.flush_ifid = 1'b1; c.flush_idex = 1'b1; c.flush_exmem = 1'b1;
      return c;
   endfunction

   task automatic pushExp(input int dut, input int kind, input logic [31:0] value, input string tag);
      exp_t e;
      e.dut = dut; e.kind = kind; e.value = value; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic expectCnt(input int dut, input int kind, input int value, input string tag);
      pushExp(dut, kind, 32'(value), tag);
   endtask

   // Pops every pending expectation and compares it with the matching DUT output.
   task automatic checkOutput();
      exp_t        e;
      logic [31:0] obs;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e.dut == 1)
            obs = (e.kind == K_CTL) ? {21'b0, ctl1} : (e.kind == K_STL) ? {28'b0, scnt1} : {28'b0, fcnt1};
         else
            obs = (e.kind == K_CTL) ? {21'b0, ctl2} : (e.kind == K_STL) ? {16'b0, scnt2} : {16'b0, fcnt2};
         n_checks++;
         assert (obs === e.value) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.value);
         end
      end
   endtask

   task automatic applyStimulus(input ins_t i1, input ins_t i2, input logic b1, input logic b2,
                                input ctl_t e1, input ctl_t e2, input string tag);
      in1 = i1; in2 = i2; br1 = b1; br2 = b2;
      pushExp(1, K_CTL, {21'b0, e1}, {tag, "/d1"});
      pushExp(2, K_CTL, {21'b0, e2}, {tag, "/d2"});
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   task automatic stepBoth(input ins_t i, input ctl_t e, input string tag);
      applyStimulus(i, i, 1'b0, 1'b0, e, e, tag);
   endtask

   task automatic expectAllCnt(input int s1, input int f1, input int s2, input int f2, input string tag);
      expectCnt(1, K_STL, s1, {tag, "_stall/d1"});
      expectCnt(1, K_FLS, f1, {tag, "_flush/d1"});
      expectCnt(2, K_STL, s2, {tag, "_stall/d2"});
      expectCnt(2, K_FLS, f2, {tag, "_flush/d2"});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; in1 = NOP; in2 = NOP; br1 = 1'b1; br2 = 1'b1;
      @(posedge clk);
      #1;
      // Reset state, with br_taken held high to show reset masks the flushes.
      expectAllCnt(0, 0, 0, 0, "rst");
      applyStimulus(NOP, NOP, 1'b1, 1'b1, ok(0, 0, 0, 0), ok(0, 0, 0, 0), "rst_out");
      rst = 1'b0;

      // ALU forwarding: back to back, one-instruction gap, MEM over WB, ID bypass.
      stepBoth(alu(3, 1, 2), ok(0, 0, 0, 0), "alu_add");
      stepBoth(alu(4, 3, 5), ok(0, 0, 0, 0), "alu_sub");
      stepBoth(NOP,          ok(2'b10, 0, 0, 0), "fwd_mem_a");
      stepBoth(NOP,          ok(0, 0, 0, 0), "fwd_idle");
      stepBoth(alu(3, 1, 2), ok(0, 0, 0, 0), "gap_add");
      stepBoth(NOP,          ok(0, 0, 0, 0), "gap_nop");
      stepBoth(alu(4, 3, 5), ok(0, 0, 0, 0), "gap_sub");
      stepBoth(NOP,          ok(2'b01, 0, 0, 0), "fwd_wb_a");
      stepBoth(alu(3, 1, 2), ok(0, 0, 0, 0), "pri_add_a");
      stepBoth(alu(3, 6, 7), ok(0, 0, 0, 0), "pri_add_b");
      stepBoth(alu(8, 9, 3), ok(0, 0, 0, 0), "pri_or");
      stepBoth(NOP,          ok(0, 2'b10, 0, 0), "fwd_mem_pri_b");
      stepBoth(alu(10, 3, 8), ok(0, 0, 1'b1, 0), "id_byp_a");
      stepBoth(NOP,          ok(0, 2'b01, 0, 0), "fwd_wb_b");
      for (int i = 0; i < 3; i++) stepBoth(NOP, ok(0, 0, 0, 0), "drain_alu");

      // Load-use: dut1 stalls once then forwards from WB; dut2 stalls twice then bypasses.
      stepBoth(lw(2, 1),     ok(0, 0, 0, 0), "lu_lw");
      stepBoth(alu(4, 2, 5), stl(0, 0), "lu_stall1");
      applyStimulus(alu(4, 2, 5), alu(4, 2, 5), 1'b0, 1'b0, ok(0, 0, 0, 0), stl(0, 0), "lu_stall2");
      applyStimulus(NOP, alu(4, 2, 5), 1'b0, 1'b0, ok(2'b01, 0, 0, 0), ok(0, 0, 1'b1, 0), "lu_release");
      expectAllCnt(1, 0, 2, 0, "lu_cnt");
      stepBoth(NOP, ok(0, 0, 0, 0), "lu_after");
      for (int i = 0; i < 3; i++) stepBoth(NOP, ok(0, 0, 0, 0), "drain_lu");

      // Register 0 as destination and source never stalls, forwards or bypasses.
      stepBoth(lw(0, 1),     ok(0, 0, 0, 0), "r0_lw");
      stepBoth(alu(0, 0, 0), ok(0, 0, 0, 0), "r0_alu");
      stepBoth(rd(0, 0),     ok(0, 0, 0, 0), "r0_rd1");
      stepBoth(rd(0, 0),     ok(0, 0, 0, 0), "r0_rd2");
      expectAllCnt(1, 0, 2, 0, "r0_cnt");
      stepBoth(NOP,          ok(0, 0, 0, 0), "r0_end");

      // Taken branch while a load-use is pending: full flush, no stall, flushed load leaves no trace.
      stepBoth(lw(2, 1), ok(0, 0, 0, 0), "br_lw");
      applyStimulus(alu(4, 2, 5), alu(4, 2, 5), 1'b1, 1'b1, brf(), brf(), "br_flush");
      expectAllCnt(1, 1, 2, 1, "br_cnt");
      stepBoth(alu(4, 2, 5), ok(0, 0, 0, 0), "br_no_stall");
      stepBoth(NOP,          ok(0, 0, 0, 0), "br_no_fwd");

      // Stall counter saturation on the 4-bit instance, consumer reading the load through rt.
      for (int k = 0; k < 20; k++) begin
         expectCnt(1, K_STL, (1 + k > 15) ? 15 : 1 + k, $sformatf("sat_stall_%0d", k));
         applyStimulus(lw(2, 1),     NOP, 1'b0, 1'b0, ok(0, 0, 0, 0), ok(0, 0, 0, 0), "sat_lw");
         applyStimulus(alu(4, 5, 2), NOP, 1'b0, 1'b0, stl(0, 0), ok(0, 0, 0, 0), "sat_stall");
         applyStimulus(alu(4, 5, 2), NOP, 1'b0, 1'b0, ok(0, 0, 0, 0), ok(0, 0, 0, 0), "sat_go");
         applyStimulus(NOP,          NOP, 1'b0, 1'b0, ok(0, 2'b01, 0, 0), ok(0, 0, 0, 0), "sat_fwd_b");
      end
      expectAllCnt(15, 1, 2, 1, "sat_end");
      stepBoth(NOP, ok(0, 0, 0, 0), "sat_idle");

      // Flush counter saturation on the 4-bit instance.
      for (int j = 0; j < 16; j++) begin
         expectCnt(1, K_FLS, (1 + j > 15) ? 15 : 1 + j, $sformatf("sat_flush_%0d", j));
         applyStimulus(NOP, NOP, 1'b1, 1'b0, brf(), ok(0, 0, 0, 0), "sat_br");
      end
      expectAllCnt(15, 15, 2, 1, "fsat_end");
      stepBoth(NOP, ok(0, 0, 0, 0), "fsat_idle");

      // Reset mid-operation discards the in-flight producer and clears the counters.
      stepBoth(alu(3, 1, 2), ok(0, 0, 0, 0), "mr_add");
      rst = 1'b1;
      applyStimulus(alu(4, 3, 5), alu(4, 3, 5), 1'b1, 1'b1, ok(0, 0, 0, 0), ok(0, 0, 0, 0), "mr_in_rst");
      rst = 1'b0;
      expectAllCnt(0, 0, 0, 0, "mr_cnt");
      stepBoth(rd(3, 3), ok(0, 0, 0, 0), "mr_no_fwd");
      stepBoth(NOP,      ok(0, 0, 0, 0), "mr_clear");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
